// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the sigma-delta CIC decimator front end.
package sdm_pkg;

  localparam int unsigned SDM_ORDER     = 3;
  localparam int unsigned SDM_DEC_RATIO = 16;
  localparam int unsigned SDM_ACC_W     = 16;

  // Signed values of a modulator bit; narrowed to ACC_W at the point of use
  localparam int SDM_POS = 1;
  localparam int SDM_NEG = -1;

  function automatic int unsigned sdm_width(input int unsigned order, input int unsigned ratio);
    return 2 + order * $clog2(ratio);
  endfunction

endpackage

// File: rtl/cic_integrator_decimator_if.sv
// Bitstream input and decimated sample output of the CIC integrator/decimator.
interface cic_integrator_decimator_if #(
  parameter int unsigned ACC_W = sdm_pkg::SDM_ACC_W
);
  logic                    ENABLE;
  logic                    bit_in;
  logic                    bit_valid;
  logic signed [ACC_W-1:0] output_data;
  logic                    sample_strobe;

  modport master (
    output ENABLE, bit_in, bit_valid,
    input  output_data, sample_strobe
  );

  modport slave (
    input  ENABLE, bit_in, bit_valid,
    output output_data, sample_strobe
  );
endinterface

// File: rtl/cic_integrator.sv
// One wrapping two's-complement accumulator stage of the CIC integrator chain.
module cic_integrator #(
  parameter int unsigned ACC_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_en,
  input  logic signed [ACC_W-1:0] i_din,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_din;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_integrator_decimator.sv
// Pipelined CIC integrator cascade for a 1-bit sigma-delta stream, decimated by DEC_RATIO.
module cic_integrator_decimator
  import sdm_pkg::*;
#(
  parameter int unsigned ORDER     = SDM_ORDER,
  parameter int unsigned DEC_RATIO = SDM_DEC_RATIO,
  parameter int unsigned ACC_W     = SDM_ACC_W
) (
  input logic                      CLK,
  input logic                      RST,
  cic_integrator_decimator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEC_RATIO);

  if (sdm_width(ORDER, DEC_RATIO) > ACC_W) begin : g_width_err
    $error("ACC_W=%0d too narrow, needs %0d", ACC_W, sdm_width(ORDER, DEC_RATIO));
  end
  if (ORDER < 1 || ORDER > 4) begin : g_order_err
    $error("ORDER=%0d outside 1..4", ORDER);
  end
  if (DEC_RATIO < 2 || DEC_RATIO > 256 || (DEC_RATIO & (DEC_RATIO - 1)) != 0) begin : g_ratio_err
    $error("DEC_RATIO=%0d must be a power of two in 2..256", DEC_RATIO);
  end

  logic                    w_accept;
  logic                    w_cnt_last;
  logic signed [ACC_W-1:0] w_int [ORDER+1];
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_out;
  logic                    r_strobe;

  assign w_accept   = bus.ENABLE & bus.bit_valid;
  assign w_cnt_last = (r_cnt == CNT_W'(DEC_RATIO - 1));
  assign w_int[0]   = bus.bit_in ? ACC_W'(SDM_POS) : ACC_W'(SDM_NEG);

  // Each stage sums the registered output of the previous one, so the chain is pipelined
  for (genvar k = 1; k <= int'(ORDER); k++) begin : g_int
    cic_integrator #(
      .ACC_W (ACC_W)
    ) u_int (
      .CLK   (CLK),
      .RST   (RST),
      .i_en  (w_accept),
      .i_din (w_int[k-1]),
      .o_acc (w_int[k])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt    <= '0;
      r_out    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_accept) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
        if (w_cnt_last) begin
          r_out    <= w_int[ORDER];
          r_strobe <= 1'b1;
        end
      end
    end
  end

  assign bus.output_data   = r_out;
  assign bus.sample_strobe = r_strobe;

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// Scoreboard bench: binomial-weight reference model feeds a queue, a negedge monitor checks it.
module tb_cic_integrator_decimator;
  import sdm_pkg::*;

  localparam int unsigned ORDER = 3;
  localparam int unsigned R     = 16;
  localparam int unsigned W     = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  cic_integrator_decimator_if #(.ACC_W(W)) bus ();

  cic_integrator_decimator #(
    .ORDER     (ORDER),
    .DEC_RATIO (R),
    .ACC_W     (W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  int         hist[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs[$];
  logic [W-1:0] last_out = '0;
  logic [W-1:0] exp_v;
  bit         recording = 1'b0;

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Output of the last integrator after m accepted inputs: sum of x[i] * C(m-1-i, ORDER-1)
  function automatic logic [W-1:0] ref_int(input int m);
    longint acc = 0;
    for (int i = 0; i < m; i++) acc += longint'(hist[i]) * binom(longint'(m - 1 - i), ORDER - 1);
    return W'(acc);
  endfunction

  task automatic drive(input bit en, input bit vld, input bit b);
    int m;
    @(posedge CLK);
    #2;
    bus.ENABLE    = en;
    bus.bit_valid = vld;
    bus.bit_in    = b;
    if (en && vld && RST) begin
      m = hist.size();
      if (m % R == R - 1) exp_q.push_back(ref_int(m));
      hist.push_back(b ? 1 : -1);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge CLK);
    #2;
    RST           = 1'b0;
    bus.ENABLE    = 1'b0;
    bus.bit_valid = 1'b0;
    hist.delete();
    exp_q.delete();
    repeat (cycles) @(posedge CLK);
    #2;
    RST = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if (bus.output_data !== '0 || bus.sample_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset: data=%0d strobe=%b required 0/0", bus.output_data,
                 bus.sample_strobe);
      end
      last_out = '0;
    end else if (bus.sample_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: data=%0d, no sample due", bus.output_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.output_data !== exp_v) begin
          errors++;
          $display("FAIL sample: got %0d required %0d", bus.output_data, exp_v);
        end
      end
      last_out = bus.output_data;
      if (recording) obs.push_back(bus.output_data);
    end else begin
      checks++;
      if (bus.output_data !== last_out) begin
        errors++;
        $display("FAIL hold: got %0d required %0d", bus.output_data, last_out);
      end
    end
  end

  initial begin
    int y;
    bus.ENABLE    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;

    // All-ones run long enough for the last integrator to wrap past 0x7FFF
    recording = 1'b1;
    repeat (10 * R) drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    recording = 1'b0;
    checks++;
    if (obs.size() != 10) begin
      errors++;
      $display("FAIL sample_count: got %0d required 10", obs.size());
    end
    for (int i = 3; i < obs.size(); i++) begin
      y = int'(obs[i]) - 3 * int'(obs[i-1]) + 3 * int'(obs[i-2]) - int'(obs[i-3]);
      checks++;
      if (W'(y) != W'(4096)) begin
        errors++;
        $display("FAIL comb[%0d]: got %0d required 4096", i, W'(y));
      end
    end

    // bit_valid on every other cycle
    for (int i = 0; i < 4 * 2 * R; i++) drive(1'b1, (i % 2) == 0, 1'b1);

    // Random bits, stalls and enable drops
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    // Mid-frame reset, then enable gaps including one right after a capture
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    do_reset(2);
    repeat (7) drive(1'b1, 1'b1, $urandom_range(0, 1) == 1);
    do_reset(3);
    repeat (5) drive(1'b1, 1'b1, $urandom_range(0, 1) == 1);
    repeat (5) drive(1'b0, 1'b1, $urandom_range(0, 1) == 1);
    repeat (11) drive(1'b1, 1'b1, $urandom_range(0, 1) == 1);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    repeat (40) drive(1'b1, 1'b1, $urandom_range(0, 1) == 1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
